// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared timing defaults and counter-width helper for the vehicle-loop sensor conditioner.
package traffic_sensor_conditioner_pkg;

  localparam int DB_CYCLES_DEF   = 4;
  localparam int HOLD_CYCLES_DEF = 8;

  // Counter width for a range 0..n, never narrower than one bit (HOLD_CYCLES may be 0).
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// One loop-sensor channel: 2-FF synchroniser, counter debouncer, presence-hold stretcher
// and rising-edge detect pulse.
module sensor_channel
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  input  logic en_i,
  output logic s_o,
  output logic det_o
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);

  logic          s1_q, s2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          sdly_q, sdly_d;

  // Outputs depend on registers only, so raw inputs never reach Sa/Sb combinationally.
  assign s_o   = deb_q | (hold_q != '0);
  assign det_o = s_o & ~sdly_q;

  always_comb begin
    deb_d  = deb_q;
    cnt_d  = '0;
    hold_d = hold_q;
    sdly_d = s_o;
    if (!en_i) begin
      deb_d  = 1'b0;
      hold_d = '0;
      sdly_d = 1'b0;
    end else begin
      if (s2_q != deb_q) begin
        if (cnt_q == CW'(DB_CYCLES - 1)) begin
          deb_d = s2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // Hold is armed on the falling edge of the debounced level and cleared while present.
      if (deb_q && !deb_d) begin
        hold_d = HW'(HOLD_CYCLES);
      end else if (deb_q) begin
        hold_d = '0;
      end else if (hold_q != '0) begin
        hold_d = hold_q - HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
      hold_q <= '0;
      sdly_q <= 1'b0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      sdly_q <= sdly_d;
    end
  end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the road A and road B loop sensors for the traffic light controller;
// two independent sensor_channel instances sharing clock, reset and enable.
module traffic_sensor_conditioner
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sa_raw,
  input  logic sb_raw,
  input  logic sensor_en,
  output logic Sa,
  output logic Sb,
  output logic det_a,
  output logic det_b
);

  sensor_channel #(
    .DB_CYCLES  (DB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_chan_a (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (sa_raw),
    .en_i   (sensor_en),
    .s_o    (Sa),
    .det_o  (det_a)
  );

  sensor_channel #(
    .DB_CYCLES  (DB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_chan_b (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (sb_raw),
    .en_i   (sensor_en),
    .s_o    (Sb),
    .det_o  (det_b)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Scoreboard bench: a window-based reference model predicts Sa/Sb/det_a/det_b per edge,
// a negedge monitor pops and compares.
module tb_traffic_sensor_conditioner;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int NEVER = -1000000;

  logic clk = 1'b0;
  logic reset_n, sa_raw, sb_raw, sensor_en;
  logic Sa, Sb, det_a, det_b;

  traffic_sensor_conditioner #(
    .DB_CYCLES  (DB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sa_raw   (sa_raw),
    .sb_raw   (sb_raw),
    .sensor_en(sensor_en),
    .Sa       (Sa),
    .Sb       (Sb),
    .det_a    (det_a),
    .det_b    (det_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int edge_n = 0;
  logic [3:0] expq[$];

  // Reference model: sync line, window of the last DB enabled samples, edge of last fall.
  bit m_s1[2], m_s2[2], m_deb[2], m_prev[2];
  bit hist[2][DB];
  int m_n[2];
  int m_fall[2];

  task automatic model_ch(input int ch, input bit raw, input bit en, input bit rstn,
                          output bit s, output bit d);
    bit samp, all_diff;
    if (!rstn) begin
      m_s1[ch] = 0; m_s2[ch] = 0; m_deb[ch] = 0; m_prev[ch] = 0;
      m_n[ch] = 0; m_fall[ch] = NEVER;
      s = 0; d = 0;
      return;
    end
    samp = m_s2[ch];
    if (!en) begin
      m_deb[ch] = 0; m_n[ch] = 0; m_fall[ch] = NEVER;
    end else begin
      for (int i = DB - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
      hist[ch][0] = samp;
      if (m_n[ch] < DB) m_n[ch]++;
      all_diff = (m_n[ch] == DB);
      for (int i = 0; i < DB; i++) if (hist[ch][i] == m_deb[ch]) all_diff = 0;
      if (all_diff) begin
        if (m_deb[ch]) m_fall[ch] = edge_n;
        m_deb[ch] = ~m_deb[ch];
      end
    end
    m_s2[ch] = m_s1[ch];
    m_s1[ch] = raw;
    s = m_deb[ch] || ((edge_n - m_fall[ch]) < HOLD);
    d = s && !m_prev[ch];
    m_prev[ch] = s;
  endtask

  task automatic step(input bit a, input bit b, input bit en);
    bit sa_e, sb_e, da_e, db_e;
    sa_raw = a; sb_raw = b; sensor_en = en;
    @(posedge clk);
    #1;
    edge_n++;
    model_ch(0, a, en, reset_n, sa_e, da_e);
    model_ch(1, b, en, reset_n, sb_e, db_e);
    expq.push_back({sa_e, sb_e, da_e, db_e});
  endtask

  task automatic steps(input int n, input bit a, input bit b, input bit en);
    for (int i = 0; i < n; i++) step(a, b, en);
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s edge=%0d got=%b expected=%b", name, edge_n, got, exp);
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if ({Sa, Sb, det_a, det_b} === e) passes++;
      else $display("FAIL outs edge=%0d got={Sa,Sb,det_a,det_b}=%b expected=%b",
                    edge_n, {Sa, Sb, det_a, det_b}, e);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog edge=%0d got=timeout expected=finish", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int la, lb;
    bit ra, rb, en;
    reset_n = 1'b0; sa_raw = 1'b0; sb_raw = 1'b0; sensor_en = 1'b1;
    #2;
    chk("reset_state", {Sa, Sb, det_a, det_b}, 4'b0000);
    steps(3, 1, 1, 1);
    reset_n = 1'b1;

    // Glitch shorter than DB on A, then a valid A assertion held high
    steps(3, 1, 0, 1);
    steps(10, 0, 0, 1);
    steps(12, 1, 0, 1);
    // Release A: debounce fall then hold stretch
    steps(20, 0, 0, 1);
    // Re-detection during hold bridges the gap
    steps(12, 1, 0, 1);
    steps(5, 0, 0, 1);
    steps(14, 1, 0, 1);
    steps(20, 0, 0, 1);
    // Simultaneous rise on both channels
    steps(14, 1, 1, 1);
    // Disable with raw high, then re-enable
    steps(3, 1, 1, 0);
    steps(10, 1, 1, 1);
    // Drop raw, land mid-hold, then assert reset asynchronously
    steps(9, 0, 0, 1);
    #5;
    chk("pre_reset_hold", {Sa, Sb, det_a, det_b}, 4'b1100);
    reset_n = 1'b0;
    #1;
    chk("async_reset", {Sa, Sb, det_a, det_b}, 4'b0000);
    steps(2, 1, 1, 1);
    reset_n = 1'b1;

    la = 0; lb = 0; ra = 0; rb = 0;
    for (int c = 0; c < 1500; c++) begin
      if (la == 0) begin ra = 1'($urandom_range(0, 1)); la = $urandom_range(1, 12); end
      if (lb == 0) begin rb = 1'($urandom_range(0, 1)); lb = $urandom_range(1, 12); end
      la--; lb--;
      en = ($urandom_range(0, 59) != 0);
      step(ra, rb, en);
    end

    steps(20, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("queue_drained", 4'(expq.size()), 4'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
